// File: rtl/inst_fetch.sv
// Instruction fetch unit: holds the PC, issues one req/gnt/rvalid fetch at a time,
// and presents returned words to decode through an output register plus a one-entry skid buffer.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic [31:0] ins_o,
   output logic [31:0] ins_addr_o,
   output logic        ins_valid_o
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] req_addr;
   logic [31:0] skid_ins;
   logic [31:0] skid_addr;
   logic        skid_valid;
   logic        consume;
   logic        resp;
   logic        jump;
   logic [31:0] jump_pc;

   // Requests stall while the skid holds a word, so a response always has somewhere to land.
   assign mem_req_o  = (state == REQ) && !skid_valid;
   assign mem_addr_o = pc;
   assign consume    = ins_valid_o && !hold_i;
   assign resp       = (state == WAIT) && mem_rvalid_i;
   assign jump       = jump_flag_i && (state != IDLE);
   assign jump_pc    = jump_addr_i & ~32'h0000_0003;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         req_addr    <= RESET_PC;
         ins_o       <= NOP_INS;
         ins_addr_o  <= RESET_PC;
         ins_valid_o <= 1'b0;
         skid_valid  <= 1'b0;
         skid_ins    <= NOP_INS;
         skid_addr   <= RESET_PC;
      end else if (jump) begin
         pc          <= jump_pc;
         ins_valid_o <= 1'b0;
         ins_o       <= NOP_INS;
         skid_valid  <= 1'b0;
         // A grant taken in the jump cycle leaves a response in flight that FLUSH must swallow.
         case (state)
            REQ:     state <= (mem_req_o && mem_gnt_i) ? FLUSH : REQ;
            WAIT:    state <= mem_rvalid_i ? REQ : FLUSH;
            FLUSH:   state <= mem_rvalid_i ? REQ : FLUSH;
            default: state <= REQ;
         endcase
      end else begin
         case (state)
            IDLE: state <= REQ;
            REQ: begin
               if (mem_req_o && mem_gnt_i) begin
                  req_addr <= pc;
                  pc       <= pc + 32'd4;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (mem_rvalid_i) state <= REQ;
            end
            FLUSH: begin
               if (mem_rvalid_i) state <= REQ;
            end
            default: state <= IDLE;
         endcase

         if (resp && (!ins_valid_o || consume)) begin
            ins_o       <= mem_rdata_i;
            ins_addr_o  <= req_addr;
            ins_valid_o <= 1'b1;
         end else if (resp) begin
            skid_valid <= 1'b1;
            skid_ins   <= mem_rdata_i;
            skid_addr  <= req_addr;
         end else if (consume && skid_valid) begin
            ins_o       <= skid_ins;
            ins_addr_o  <= skid_addr;
            ins_valid_o <= 1'b1;
            skid_valid  <= 1'b0;
         end else if (consume) begin
            ins_valid_o <= 1'b0;
            ins_o       <= NOP_INS;
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed stimulus pushes expected {addr, ins} pairs,
// independent monitors compare them against whatever the DUTs present to decode.
module tb_inst_fetch;

   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [31:0] MASK    = 32'hA5A5_0000;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        jump_flag_i = 1'b0;
   logic [31:0] jump_addr_i = '0;
   logic        hold_i = 1'b0;

   logic        mem_req_o, ins_valid_o;
   logic [31:0] mem_addr_o, ins_o, ins_addr_o;
   logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;

   logic        w_req, w_valid;
   logic [31:0] w_addr, w_ins, w_ins_addr;
   logic        w_gnt = 1'b0, w_rvalid = 1'b0;
   logic [31:0] w_rdata = '0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] ins;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        w_q[$];
   logic [31:0] w_grants[$];

   int          checks = 0;
   int          errors = 0;
   int          budget = 0, w_budget = 0;
   bit          pend = 0, w_pend = 0, rv_hold = 0;
   logic [31:0] pend_addr = '0, w_pend_addr = '0;

   inst_fetch u_dut (
      .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .hold_i(hold_i),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .ins_o(ins_o), .ins_addr_o(ins_addr_o), .ins_valid_o(ins_valid_o)
   );

   inst_fetch #(.RESET_PC(WRAP_PC), .NOP_INS(NOP)) u_wrap (
      .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .hold_i(hold_i),
      .mem_req_o(w_req), .mem_addr_o(w_addr), .mem_gnt_i(w_gnt),
      .mem_rvalid_i(w_rvalid), .mem_rdata_i(w_rdata),
      .ins_o(w_ins), .ins_addr_o(w_ins_addr), .ins_valid_o(w_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one cycle and play both memories: rvalid one cycle after each grant.
   task automatic step();
      @(posedge clk);
      #1;
      jump_flag_i = 1'b0;
      if (pend && !rv_hold) begin
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = pend_addr ^ MASK;
         pend         = 1'b0;
      end else begin
         mem_rvalid_i = 1'b0;
         mem_rdata_i  = '0;
      end
      mem_gnt_i = mem_req_o && (budget > 0);
      if (mem_gnt_i) begin
         budget--;
         pend      = 1'b1;
         pend_addr = mem_addr_o;
      end
      if (w_pend) begin
         w_rvalid = 1'b1;
         w_rdata  = w_pend_addr ^ MASK;
         w_pend   = 1'b0;
      end else begin
         w_rvalid = 1'b0;
         w_rdata  = '0;
      end
      w_gnt = w_req && (w_budget > 0);
      if (w_gnt) begin
         w_budget--;
         w_pend      = 1'b1;
         w_pend_addr = w_addr;
         w_grants.push_back(w_addr);
      end
   endtask

   task automatic push(input logic [31:0] a);
      exp_q.push_back('{addr: a, ins: a ^ MASK});
   endtask

   task automatic drain(input bit wrap, input string name);
      int n = 0;
      while (((wrap ? w_q.size() : exp_q.size()) != 0) && n < 60) begin
         step();
         n++;
      end
      check(name, 32'(wrap ? w_q.size() : exp_q.size()), 32'd0);
   endtask

   task automatic do_reset(input bit keep_pend);
      rst = 1'b1;
      hold_i = 1'b0;
      jump_flag_i = 1'b0;
      budget = 0;
      w_budget = 0;
      if (!keep_pend) begin
         pend = 1'b0;
         rv_hold = 1'b0;
      end
      w_pend = 1'b0;
      exp_q.delete();
      w_q.delete();
      repeat (3) step();
      rst = 1'b0;
   endtask

   initial begin : monitor_main
      forever begin
         @(negedge clk);
         if (!rst && ins_valid_o) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ins_addr", ins_addr_o, 32'hDEAD_BEEF);
            end else begin
               check("sb_ins_addr", ins_addr_o, exp_q[0].addr);
               check("sb_ins", ins_o, exp_q[0].ins);
               if (!hold_i) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin : monitor_wrap
      forever begin
         @(negedge clk);
         if (!rst && w_valid) begin
            if (w_q.size() == 0) begin
               check("wrap_unexpected_addr", w_ins_addr, 32'hDEAD_BEEF);
            end else begin
               check("wrap_sb_ins_addr", w_ins_addr, w_q[0].addr);
               check("wrap_sb_ins", w_ins, w_q[0].ins);
               if (!hold_i) void'(w_q.pop_front());
            end
         end
      end
   end

   initial begin : stimulus
      int n;

      // Reset held three cycles, then release.
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_req", 32'(mem_req_o), 32'd0);
         check("rst_addr", mem_addr_o, 32'h0);
         check("rst_ins", ins_o, NOP);
         check("rst_ins_addr", ins_addr_o, 32'h0);
         check("rst_valid", 32'(ins_valid_o), 32'd0);
      end
      rst = 1'b0;
      check("idle_no_req", 32'(mem_req_o), 32'd0);
      step();
      check("first_req", 32'(mem_req_o), 32'd1);
      check("first_addr", mem_addr_o, 32'h0);

      // Zero-wait stream: grant in N, rvalid in N+1, valid in N+2, one word per 2 cycles.
      push(32'h0); push(32'h4); push(32'h8);
      budget = 3;
      step();
      check("zw_n0_valid", 32'(ins_valid_o), 32'd0);
      step();
      check("zw_n1_valid", 32'(ins_valid_o), 32'd0);
      step();
      check("zw_n2_valid", 32'(ins_valid_o), 32'd1);
      check("zw_n2_addr", ins_addr_o, 32'h0);
      step();
      check("zw_n3_valid", 32'(ins_valid_o), 32'd0);
      step();
      check("zw_n4_valid", 32'(ins_valid_o), 32'd1);
      check("zw_n4_addr", ins_addr_o, 32'h4);
      drain(1'b0, "zw_drain");

      // Hold for 6 cycles from first delivery; 0x4 lands in the skid.
      do_reset(1'b0);
      step();
      push(32'h0); push(32'h4);
      budget = 3;
      n = 0;
      do begin
         step();
         n++;
      end while (!ins_valid_o && n < 20);
      check("hold_first_valid", 32'(ins_valid_o), 32'd1);
      hold_i = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         check("hold_out_addr", ins_addr_o, 32'h0);
         if (i >= 2) check("hold_skid_no_req", 32'(mem_req_o), 32'd0);
      end
      step();
      hold_i = 1'b0;
      check("hold_rel_addr0", ins_addr_o, 32'h0);
      rv_hold = 1'b1;
      step();
      check("hold_rel_addr4", ins_addr_o, 32'h4);
      check("hold_resume_req", 32'(mem_req_o), 32'd1);
      check("hold_resume_addr", mem_addr_o, 32'h8);

      // Jump to 0x100 while the 0x8 response is outstanding.
      step();
      check("jw_in_wait", 32'(mem_req_o), 32'd0);
      jump_flag_i = 1'b1;
      jump_addr_i = 32'h100;
      step();
      check("jw_valid", 32'(ins_valid_o), 32'd0);
      check("jw_addr", mem_addr_o, 32'h100);
      check("jw_flush_no_req", 32'(mem_req_o), 32'd0);
      rv_hold = 1'b0;
      step();
      check("jw_drop_valid", 32'(ins_valid_o), 32'd0);
      push(32'h100);
      budget = 1;
      step();
      check("jw_req", 32'(mem_req_o), 32'd1);
      check("jw_req_addr", mem_addr_o, 32'h100);
      drain(1'b0, "jw_drain");

      // Jump to misaligned 0x103 in the same cycle as a grant, with a held word on the outputs.
      hold_i = 1'b1;
      push(32'h104);
      budget = 1;
      n = 0;
      do begin
         step();
         n++;
      end while (!ins_valid_o && n < 20);
      check("jg_held_addr", ins_addr_o, 32'h104);
      budget = 1;
      step();
      jump_flag_i = 1'b1;
      jump_addr_i = 32'h103;
      step();
      check("jg_valid", 32'(ins_valid_o), 32'd0);
      check("jg_nop", ins_o, NOP);
      check("jg_addr", mem_addr_o, 32'h100);
      check("jg_flush_no_req", 32'(mem_req_o), 32'd0);
      exp_q.delete();
      hold_i = 1'b0;
      step();
      check("jg_drop_valid", 32'(ins_valid_o), 32'd0);
      push(32'h100);
      budget = 1;
      step();
      check("jg_req", 32'(mem_req_o), 32'd1);
      check("jg_req_addr", mem_addr_o, 32'h100);
      drain(1'b0, "jg_drain");

      // Reset mid-transaction; the late rvalid must be ignored.
      rv_hold = 1'b1;
      budget = 1;
      step();
      step();
      do_reset(1'b1);
      rv_hold = 1'b0;
      step();
      step();
      check("late_rv_valid", 32'(ins_valid_o), 32'd0);
      check("late_rv_req", 32'(mem_req_o), 32'd1);
      check("late_rv_addr", mem_addr_o, 32'h0);
      step();
      check("late_rv_valid2", 32'(ins_valid_o), 32'd0);

      // PC wrap from 0xFFFFFFFC to 0x0.
      do_reset(1'b0);
      w_grants.delete();
      step();
      check("wrap_first_addr", w_addr, WRAP_PC);
      w_q.push_back('{addr: WRAP_PC, ins: WRAP_PC ^ MASK});
      w_q.push_back('{addr: 32'h0, ins: 32'h0 ^ MASK});
      w_budget = 2;
      drain(1'b1, "wrap_drain");
      check("wrap_ngrants", 32'(w_grants.size()), 32'd2);
      if (w_grants.size() >= 2) check("wrap_second_req", w_grants[1], 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit feeding the decode stage. Holds the PC and issues one word request at a time on a req/gnt/rvalid memory port. Returned words reach decode as `ins_o`/`ins_addr_o` qualified by `ins_valid_o`, with back-pressure from `hold_i`. Jump redirects from execute flush the fetch path and squash any request still in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INS`, default 32'h0000_0013: value driven on `ins_o` whenever no valid instruction is present.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `jump_flag_i`  in  1  redirect request from execute.
- `jump_addr_i`  in  32  redirect target; bits [1:0] are forced to 0.
- `hold_i`  in  1  decode cannot accept the instruction on the outputs this cycle.
- `mem_req_o`  out  1  fetch request.
- `mem_addr_o`  out  32  fetch address; always equal to the PC register.
- `mem_gnt_i`  in  1  request accepted this cycle.
- `mem_rvalid_i`  in  1  read data valid; exactly one per grant, in order, at least 1 cycle after the grant.
- `mem_rdata_i`  in  32  instruction word.
- `ins_o`  out  32  instruction to decode (registered).
- `ins_addr_o`  out  32  address of `ins_o` (registered).
- `ins_valid_o`  out  1  `ins_o` is valid (registered).

## Operation
- **State machine:** IDLE, REQ, WAIT, FLUSH.
  - IDLE lasts one cycle after reset, then moves to REQ.
  - REQ: `mem_req_o` = 1 only while the skid buffer is empty.
    - On `mem_gnt_i` with a request asserted: capture `req_addr` <= pc, set pc <= pc+4 (mod 2^32, so 0xFFFFFFFC wraps to 0), and move to WAIT.
  - WAIT: on `mem_rvalid_i`, deliver the word (see Output buffering) and return to REQ.
  - FLUSH: discard the next `mem_rvalid_i`, then move to REQ.
- **Output buffering:** one output register plus a one-entry skid buffer. A word is consumed when `ins_valid_o` = 1 and `hold_i` = 0.
  - Response arrives, and the output register is empty or being consumed: load `ins_o` <= rdata, `ins_addr_o` <= `req_addr`, `ins_valid_o` <= 1.
  - Response arrives while the output is valid and held: store {rdata, `req_addr`} in the skid buffer.
  - Output consumed while the skid buffer is full: skid moves to output; skid becomes empty.
  - Output consumed with nothing to replace it: `ins_valid_o` <= 0 and `ins_o` <= `NOP_INS`.
  - A response can never arrive while the skid buffer is full, because requests are blocked while it is full.
- **Jump** (highest priority, any state except IDLE):
  - pc <= {`jump_addr_i`[31:2], 2'b00}.
  - Output and skid are invalidated: `ins_valid_o` <= 0, `ins_o` <= `NOP_INS`.
  - Next state:
    - REQ without grant: REQ.
    - REQ with grant in the same cycle: FLUSH; no pc+4.
    - WAIT without `mem_rvalid_i`: FLUSH.
    - WAIT with `mem_rvalid_i`: REQ, and the data is dropped.
    - FLUSH with `mem_rvalid_i`: REQ.
    - FLUSH without `mem_rvalid_i`: stays FLUSH.
- `mem_rvalid_i` in IDLE or REQ is ignored.

## Timing
- **Reset values:** state IDLE, pc = `RESET_PC`, `mem_req_o` = 0, `mem_addr_o` = `RESET_PC`, `ins_o` = `NOP_INS`, `ins_addr_o` = `RESET_PC`, `ins_valid_o` = 0, skid empty.
- Reset asserted mid-transaction takes effect immediately; a late `mem_rvalid_i` after reset is ignored.
- First `mem_req_o` appears in the 2nd cycle after `rst` deasserts.
- **Latency:** with the grant in cycle N and rvalid in N+1, `ins_valid_o` rises in N+2.
- **Throughput:** at most one instruction per 2 cycles; one outstanding request.
- Jump in cycle J: `mem_addr_o` equals the target from J+1, and `ins_valid_o` is 0 from J+1.
- While `mem_req_o` = 1 and ungranted, `mem_addr_o` is stable except on a jump.

## Test plan
- **Reset:** `rst` = 1 for 3 cycles, then release. Required: all outputs at their reset values during reset; `mem_req_o` = 1 with `mem_addr_o` = 0x0 in cycle 2 after release.
- **Zero-wait stream:** immediate grant, rvalid one cycle later, rdata = addr ^ 0xA5A5_0000, `hold_i` = 0. Required: `ins_addr_o` = 0x0, 0x4, 0x8 on every other cycle, with matching `ins_o`.
- **Hold:** `hold_i` = 1 for 6 cycles after the first delivery. Required: word 0x0 held on the outputs; word 0x4 captured in the skid buffer; `mem_req_o` = 0 while the skid is full. On release: 0x0 then 0x4 on consecutive cycles, then fetch of 0x8 resumes.
- **Jump in WAIT:** jump to 0x100 while the 0x8 response is outstanding. Required: the 0x8 data is dropped, `ins_valid_o` = 0, next request is at 0x100, and the first delivered `ins_addr_o` = 0x100.
- **Jump with grant / misaligned target:** jump to 0x103 in the same cycle as a grant. Required: FLUSH discards one response, and the next request is at 0x100.
- **Wrap:** `RESET_PC` = 0xFFFFFFFC. Required: the second request address is 0x0, and `ins_addr_o` sequence is 0xFFFFFFFC, 0x0.
